// File: rtl/iq_request_gen.sv
// iq_request_gen
// Per-entry readiness tracker feeding the root of the issue select tree.
// Each issue-queue entry keeps a valid bit, two source tags and two source
// ready bits. Dispatch writes entries, wakeup broadcasts set ready bits, and
// the final grant vector from the select tree retires entries.
//
// Ports:
//   clk              rising-edge clock
//   reset            asynchronous, active-low reset
//   dispatchValid_i  per-lane dispatch strobe
//   dispatchEntry_i  per-lane target entry index
//   src1Tag_i        per-lane source 1 physical tag
//   src2Tag_i        per-lane source 2 physical tag
//   src1Rdy_i        per-lane source 1 ready at rename
//   src2Rdy_i        per-lane source 2 ready at rename
//   wakeupValid_i    per-port wakeup broadcast strobe
//   wakeupTag_i      per-port wakeup destination tag
//   grant_i          final per-entry grant from the select tree
//   flush_i          pipeline flush
//   req_o            per-entry request into the select tree (flop-driven)
//   freed_o          entries retired on the previous edge, to the free list
//   count_o          number of valid entries
module iq_request_gen #(
  parameter int SIZE_IQ           = 16,
  parameter int SIZE_IQ_LOG       = 4,
  parameter int SIZE_PHYSICAL_LOG = 7,
  parameter int DISPATCH_WIDTH    = 2,
  parameter int WAKEUP_WIDTH      = 4
) (
  input  logic                                              clk,
  input  logic                                              reset,
  input  logic [DISPATCH_WIDTH-1:0]                         dispatchValid_i,
  input  logic [DISPATCH_WIDTH-1:0][SIZE_IQ_LOG-1:0]        dispatchEntry_i,
  input  logic [DISPATCH_WIDTH-1:0][SIZE_PHYSICAL_LOG-1:0]  src1Tag_i,
  input  logic [DISPATCH_WIDTH-1:0][SIZE_PHYSICAL_LOG-1:0]  src2Tag_i,
  input  logic [DISPATCH_WIDTH-1:0]                         src1Rdy_i,
  input  logic [DISPATCH_WIDTH-1:0]                         src2Rdy_i,
  input  logic [WAKEUP_WIDTH-1:0]                           wakeupValid_i,
  input  logic [WAKEUP_WIDTH-1:0][SIZE_PHYSICAL_LOG-1:0]    wakeupTag_i,
  input  logic [SIZE_IQ-1:0]                                grant_i,
  input  logic                                              flush_i,
  output logic [SIZE_IQ-1:0]                                req_o,
  output logic [SIZE_IQ-1:0]                                freed_o,
  output logic [SIZE_IQ_LOG:0]                              count_o
);

  typedef logic [SIZE_PHYSICAL_LOG-1:0] tag_t;

  logic [SIZE_IQ-1:0] valid_r, rdy1_r, rdy2_r, freed_r;
  logic [SIZE_IQ-1:0] valid_s, rdy1_s, rdy2_s, freed_s;
  tag_t [SIZE_IQ-1:0] tag1_r, tag2_r;
  tag_t [SIZE_IQ-1:0] tag1_s, tag2_s;
  logic [SIZE_IQ-1:0] req_s;
  logic [SIZE_IQ-1:0] issued_s;

  // True when any valid wakeup port broadcasts the given tag.
  function automatic logic tag_match(
    input tag_t                                           tag,
    input logic [WAKEUP_WIDTH-1:0]                        wv,
    input logic [WAKEUP_WIDTH-1:0][SIZE_PHYSICAL_LOG-1:0] wt
  );
    logic hit;
    hit = 1'b0;
    for (int w = 0; w < WAKEUP_WIDTH; w++) begin
      hit = hit | (wv[w] & (wt[w] == tag));
    end
    return hit;
  endfunction

  // Number of set bits in an entry vector.
  function automatic logic [SIZE_IQ_LOG:0] popcount(input logic [SIZE_IQ-1:0] v);
    logic [SIZE_IQ_LOG:0] cnt;
    cnt = '0;
    for (int i = 0; i < SIZE_IQ; i++) begin
      cnt = cnt + (SIZE_IQ_LOG+1)'(v[i]);
    end
    return cnt;
  endfunction

  // Request and issue vectors are built from flops only; grant bits on
  // non-requesting entries drop out here.
  assign req_s    = valid_r & rdy1_r & rdy2_r;
  assign issued_s = grant_i & req_s;

  // Next-state per entry, priority flush > dispatch > retire > wakeup.
  always_comb begin
    valid_s = valid_r;
    rdy1_s  = rdy1_r;
    rdy2_s  = rdy2_r;
    tag1_s  = tag1_r;
    tag2_s  = tag2_r;
    freed_s = '0;
    for (int i = 0; i < SIZE_IQ; i++) begin
      logic d_hit;
      logic lane_hit;
      tag_t d_tag1;
      tag_t d_tag2;
      logic d_rdy1;
      logic d_rdy2;
      d_hit  = 1'b0;
      d_tag1 = '0;
      d_tag2 = '0;
      d_rdy1 = 1'b0;
      d_rdy2 = 1'b0;
      // Two lanes hitting one entry is illegal; the higher lane simply wins.
      for (int d = 0; d < DISPATCH_WIDTH; d++) begin
        lane_hit = dispatchValid_i[d] & (dispatchEntry_i[d] == SIZE_IQ_LOG'(i));
        d_hit    = d_hit | lane_hit;
        d_tag1   = lane_hit ? src1Tag_i[d] : d_tag1;
        d_tag2   = lane_hit ? src2Tag_i[d] : d_tag2;
        d_rdy1   = lane_hit ? src1Rdy_i[d] : d_rdy1;
        d_rdy2   = lane_hit ? src2Rdy_i[d] : d_rdy2;
      end
      if (flush_i) begin
        valid_s[i] = 1'b0;
        rdy1_s[i]  = 1'b0;
        rdy2_s[i]  = 1'b0;
        freed_s[i] = 1'b0;
      end else if (d_hit) begin
        // Same-cycle wakeup bypass so a dispatch racing its producer's
        // broadcast does not miss the wakeup forever.
        valid_s[i] = 1'b1;
        tag1_s[i]  = d_tag1;
        tag2_s[i]  = d_tag2;
        rdy1_s[i]  = d_rdy1 | tag_match(d_tag1, wakeupValid_i, wakeupTag_i);
        rdy2_s[i]  = d_rdy2 | tag_match(d_tag2, wakeupValid_i, wakeupTag_i);
        freed_s[i] = issued_s[i];
      end else if (issued_s[i]) begin
        valid_s[i] = 1'b0;
        freed_s[i] = 1'b1;
      end else if (valid_r[i]) begin
        rdy1_s[i]  = rdy1_r[i] | tag_match(tag1_r[i], wakeupValid_i, wakeupTag_i);
        rdy2_s[i]  = rdy2_r[i] | tag_match(tag2_r[i], wakeupValid_i, wakeupTag_i);
        freed_s[i] = 1'b0;
      end else begin
        valid_s[i] = 1'b0;
        freed_s[i] = 1'b0;
      end
    end
  end

  // Entry state and freed vector registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_r <= '0;
      rdy1_r  <= '0;
      rdy2_r  <= '0;
      tag1_r  <= '0;
      tag2_r  <= '0;
      freed_r <= '0;
    end else begin
      valid_r <= valid_s;
      rdy1_r  <= rdy1_s;
      rdy2_r  <= rdy2_s;
      tag1_r  <= tag1_s;
      tag2_r  <= tag2_s;
      freed_r <= freed_s;
    end
  end

  assign req_o   = req_s;
  assign freed_o = freed_r;
  assign count_o = popcount(valid_r);

endmodule

// File: tb/tb_iq_request_gen.sv
module tb_iq_request_gen;

  logic             clk;
  logic             reset;
  logic [1:0]       dispatchValid_i;
  logic [1:0][3:0]  dispatchEntry_i;
  logic [1:0][6:0]  src1Tag_i;
  logic [1:0][6:0]  src2Tag_i;
  logic [1:0]       src1Rdy_i;
  logic [1:0]       src2Rdy_i;
  logic [3:0]       wakeupValid_i;
  logic [3:0][6:0]  wakeupTag_i;
  logic [15:0]      grant_i;
  logic             flush_i;
  logic [15:0]      req_o;
  logic [15:0]      freed_o;
  logic [4:0]       count_o;

  int checks = 0;
  int errors = 0;

  iq_request_gen dut (
    .clk             (clk),
    .reset           (reset),
    .dispatchValid_i (dispatchValid_i),
    .dispatchEntry_i (dispatchEntry_i),
    .src1Tag_i       (src1Tag_i),
    .src2Tag_i       (src2Tag_i),
    .src1Rdy_i       (src1Rdy_i),
    .src2Rdy_i       (src2Rdy_i),
    .wakeupValid_i   (wakeupValid_i),
    .wakeupTag_i     (wakeupTag_i),
    .grant_i         (grant_i),
    .flush_i         (flush_i),
    .req_o           (req_o),
    .freed_o         (freed_o),
    .count_o         (count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    dispatchValid_i = 2'b00;
    dispatchEntry_i = '0;
    src1Tag_i       = '0;
    src2Tag_i       = '0;
    src1Rdy_i       = 2'b00;
    src2Rdy_i       = 2'b00;
    wakeupValid_i   = 4'b0000;
    wakeupTag_i     = '0;
    grant_i         = 16'h0000;
    flush_i         = 1'b0;
  endtask

  task automatic set_lane(input int lane, input logic [3:0] entry,
                          input logic [6:0] t1, input logic r1,
                          input logic [6:0] t2, input logic r2);
    dispatchValid_i[lane] = 1'b1;
    dispatchEntry_i[lane] = entry;
    src1Tag_i[lane]       = t1;
    src1Rdy_i[lane]       = r1;
    src2Tag_i[lane]       = t2;
    src2Rdy_i[lane]       = r2;
  endtask

  task automatic set_wakeup(input int port, input logic [6:0] tag);
    wakeupValid_i[port] = 1'b1;
    wakeupTag_i[port]   = tag;
  endtask

  // Inputs applied after a negedge take effect at the next posedge; outputs
  // are sampled on the following negedge, then inputs return to idle.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (req_o !== 16'h0000) begin errors++; $display("FAIL reset_req got %h exp %h", req_o, 16'h0000); end
    checks++; if (freed_o !== 16'h0000) begin errors++; $display("FAIL reset_freed got %h exp %h", freed_o, 16'h0000); end
    checks++; if (count_o !== 5'd0) begin errors++; $display("FAIL reset_count got %0d exp %0d", count_o, 5'd0); end
    reset = 1'b1;
    step();
    checks++; if (req_o !== 16'h0000) begin errors++; $display("FAIL post_reset_req got %h exp %h", req_o, 16'h0000); end
  endtask

  task automatic test_dispatch_ready();
    set_lane(0, 4'd3, 7'h00, 1'b1, 7'h00, 1'b1);
    step();
    checks++; if (req_o !== 16'h0008) begin errors++; $display("FAIL dispatch_req got %h exp %h", req_o, 16'h0008); end
    checks++; if (count_o !== 5'd1) begin errors++; $display("FAIL dispatch_count got %0d exp %0d", count_o, 5'd1); end
  endtask

  task automatic test_wakeup();
    set_lane(1, 4'd5, 7'h12, 1'b0, 7'h13, 1'b1);
    step();
    checks++; if (req_o !== 16'h0008) begin errors++; $display("FAIL wake_wait0_req got %h exp %h", req_o, 16'h0008); end
    checks++; if (count_o !== 5'd2) begin errors++; $display("FAIL wake_count got %0d exp %0d", count_o, 5'd2); end
    step();
    checks++; if (req_o !== 16'h0008) begin errors++; $display("FAIL wake_wait1_req got %h exp %h", req_o, 16'h0008); end
    set_wakeup(2, 7'h12);
    step();
    checks++; if (req_o !== 16'h0028) begin errors++; $display("FAIL wake_req got %h exp %h", req_o, 16'h0028); end
  endtask

  task automatic test_retire();
    grant_i = 16'h0020;
    step();
    checks++; if (req_o !== 16'h0008) begin errors++; $display("FAIL retire_req got %h exp %h", req_o, 16'h0008); end
    checks++; if (freed_o !== 16'h0020) begin errors++; $display("FAIL retire_freed got %h exp %h", freed_o, 16'h0020); end
    checks++; if (count_o !== 5'd1) begin errors++; $display("FAIL retire_count got %0d exp %0d", count_o, 5'd1); end
    grant_i = 16'h0100;
    step();
    checks++; if (req_o !== 16'h0008) begin errors++; $display("FAIL spurious_req got %h exp %h", req_o, 16'h0008); end
    checks++; if (freed_o !== 16'h0000) begin errors++; $display("FAIL spurious_freed got %h exp %h", freed_o, 16'h0000); end
    checks++; if (count_o !== 5'd1) begin errors++; $display("FAIL spurious_count got %0d exp %0d", count_o, 5'd1); end
  endtask

  task automatic test_bypass();
    // Entry 7 sees its tag on a valid port; entry 9 only on an invalid port.
    set_lane(0, 4'd7, 7'h20, 1'b0, 7'h40, 1'b1);
    set_lane(1, 4'd9, 7'h21, 1'b0, 7'h41, 1'b1);
    set_wakeup(0, 7'h20);
    wakeupTag_i[1] = 7'h21;
    step();
    checks++; if (req_o !== 16'h0088) begin errors++; $display("FAIL bypass_req got %h exp %h", req_o, 16'h0088); end
    checks++; if (count_o !== 5'd3) begin errors++; $display("FAIL bypass_count got %0d exp %0d", count_o, 5'd3); end
  endtask

  task automatic test_dual_wakeup();
    set_lane(0, 4'd10, 7'h30, 1'b0, 7'h31, 1'b0);
    step();
    checks++; if (req_o !== 16'h0088) begin errors++; $display("FAIL dual_pre_req got %h exp %h", req_o, 16'h0088); end
    checks++; if (count_o !== 5'd4) begin errors++; $display("FAIL dual_count got %0d exp %0d", count_o, 5'd4); end
    grant_i = 16'h0400;
    step();
    checks++; if (freed_o !== 16'h0000) begin errors++; $display("FAIL nonreq_grant_freed got %h exp %h", freed_o, 16'h0000); end
    checks++; if (count_o !== 5'd4) begin errors++; $display("FAIL nonreq_grant_count got %0d exp %0d", count_o, 5'd4); end
    set_wakeup(1, 7'h30);
    set_wakeup(3, 7'h31);
    set_wakeup(0, 7'h21);
    step();
    checks++; if (req_o !== 16'h0688) begin errors++; $display("FAIL dual_req got %h exp %h", req_o, 16'h0688); end
  endtask

  task automatic test_back_to_back();
    grant_i = 16'h0008;
    step();
    checks++; if (req_o !== 16'h0680) begin errors++; $display("FAIL b2b_grant_req got %h exp %h", req_o, 16'h0680); end
    checks++; if (freed_o !== 16'h0008) begin errors++; $display("FAIL b2b_grant_freed got %h exp %h", freed_o, 16'h0008); end
    checks++; if (count_o !== 5'd3) begin errors++; $display("FAIL b2b_grant_count got %0d exp %0d", count_o, 5'd3); end
    set_lane(0, 4'd3, 7'h05, 1'b1, 7'h06, 1'b1);
    step();
    checks++; if (req_o !== 16'h0688) begin errors++; $display("FAIL b2b_redisp_req got %h exp %h", req_o, 16'h0688); end
    checks++; if (freed_o !== 16'h0000) begin errors++; $display("FAIL b2b_redisp_freed got %h exp %h", freed_o, 16'h0000); end
    checks++; if (count_o !== 5'd4) begin errors++; $display("FAIL b2b_redisp_count got %0d exp %0d", count_o, 5'd4); end
  endtask

  task automatic test_flush_full();
    logic [3:0] fill [12];
    fill = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd5, 4'd6, 4'd8, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15};
    for (int k = 0; k < 12; k += 2) begin
      set_lane(0, fill[k],   7'h50, 1'b1, 7'h51, 1'b1);
      set_lane(1, fill[k+1], 7'h52, 1'b1, 7'h53, 1'b1);
      step();
    end
    checks++; if (req_o !== 16'hFFFF) begin errors++; $display("FAIL full_req got %h exp %h", req_o, 16'hFFFF); end
    checks++; if (count_o !== 5'd16) begin errors++; $display("FAIL full_count got %0d exp %0d", count_o, 5'd16); end
    flush_i = 1'b1;
    grant_i = 16'hFFFF;
    set_lane(0, 4'd0, 7'h01, 1'b1, 7'h02, 1'b1);
    step();
    checks++; if (req_o !== 16'h0000) begin errors++; $display("FAIL flush_req got %h exp %h", req_o, 16'h0000); end
    checks++; if (freed_o !== 16'h0000) begin errors++; $display("FAIL flush_freed got %h exp %h", freed_o, 16'h0000); end
    checks++; if (count_o !== 5'd0) begin errors++; $display("FAIL flush_count got %0d exp %0d", count_o, 5'd0); end
  endtask

  task automatic test_async_reset();
    set_lane(0, 4'd0, 7'h00, 1'b1, 7'h00, 1'b1);
    set_lane(1, 4'd1, 7'h00, 1'b1, 7'h00, 1'b1);
    step();
    set_lane(0, 4'd2, 7'h00, 1'b1, 7'h00, 1'b1);
    set_lane(1, 4'd3, 7'h00, 1'b1, 7'h00, 1'b1);
    step();
    set_lane(0, 4'd4, 7'h00, 1'b1, 7'h00, 1'b1);
    step();
    grant_i = 16'h0010;
    step();
    checks++; if (req_o !== 16'h000F) begin errors++; $display("FAIL pre_areset_req got %h exp %h", req_o, 16'h000F); end
    checks++; if (freed_o !== 16'h0010) begin errors++; $display("FAIL pre_areset_freed got %h exp %h", freed_o, 16'h0010); end
    checks++; if (count_o !== 5'd4) begin errors++; $display("FAIL pre_areset_count got %0d exp %0d", count_o, 5'd4); end
    // Pulse reset well clear of the next posedge.
    #1 reset = 1'b0;
    #1;
    checks++; if (req_o !== 16'h0000) begin errors++; $display("FAIL areset_req got %h exp %h", req_o, 16'h0000); end
    checks++; if (freed_o !== 16'h0000) begin errors++; $display("FAIL areset_freed got %h exp %h", freed_o, 16'h0000); end
    checks++; if (count_o !== 5'd0) begin errors++; $display("FAIL areset_count got %0d exp %0d", count_o, 5'd0); end
    #1 reset = 1'b1;
    @(negedge clk);
    checks++; if (count_o !== 5'd0) begin errors++; $display("FAIL post_areset_count got %0d exp %0d", count_o, 5'd0); end
    set_lane(0, 4'd6, 7'h00, 1'b1, 7'h00, 1'b1);
    step();
    checks++; if (req_o !== 16'h0040) begin errors++; $display("FAIL post_areset_req got %h exp %h", req_o, 16'h0040); end
    checks++; if (count_o !== 5'd1) begin errors++; $display("FAIL post_areset_disp_count got %0d exp %0d", count_o, 5'd1); end
  endtask

  initial begin
    test_reset();
    test_dispatch_ready();
    test_wakeup();
    test_retire();
    test_bypass();
    test_dual_wakeup();
    test_back_to_back();
    test_flush_full();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
